// File: rtl/rx_drain_arbiter.sv
// Round-robin drain of NPORTS serial receivers into one valid/ready stream.
// Grants a receiver holding an item, pulses its item_read once, and holds the word until accepted.
module rx_drain_arbiter #(
    parameter int NPORTS = 5,
    parameter int SIZE   = 8,
    parameter int PORT_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NPORTS-1:0]      rx_valid,
    input  logic [NPORTS*SIZE-1:0] rx_data,
    output logic [NPORTS-1:0]      rx_item_read,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SIZE-1:0]        out_data,
    output logic [PORT_W-1:0]      out_port,
    output logic [CNT_W-1:0]       item_count
);

    typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;

    state_t              state, state_nxt;
    logic [PORT_W-1:0]   rr_ptr, rr_nxt;
    logic [NPORTS-1:0]   read_nxt;
    logic                valid_nxt;
    logic [SIZE-1:0]     data_nxt;
    logic [PORT_W-1:0]   port_nxt;
    logic [CNT_W-1:0]    count_nxt;

    logic                hi_found, lo_found;
    logic [PORT_W-1:0]   hi_idx, lo_idx, grant;
    logic [SIZE-1:0]     gnt_data;
    logic [NPORTS-1:0]   gnt_onehot;

    // Round-robin pick: lowest valid index at/after rr_ptr, else lowest valid overall (wrap).
    // Only the granted word is selected, so X on idle receivers never reaches out_data.
    always_comb begin
        hi_found   = 1'b0;
        lo_found   = 1'b0;
        hi_idx     = '0;
        lo_idx     = '0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            if (rx_valid[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = PORT_W'(i);
            end
            if (rx_valid[i] && !hi_found && (PORT_W'(i) >= rr_ptr)) begin
                hi_found = 1'b1;
                hi_idx   = PORT_W'(i);
            end
        end
        grant      = hi_found ? hi_idx : lo_idx;
        gnt_data   = '0;
        gnt_onehot = '0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            if (PORT_W'(i) == grant) begin
                gnt_data      = rx_data[i*SIZE +: SIZE];
                gnt_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        read_nxt  = '0;
        valid_nxt = out_valid;
        data_nxt  = out_data;
        port_nxt  = out_port;
        count_nxt = item_count;
        case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                if (|rx_valid) begin
                    data_nxt  = gnt_data;
                    port_nxt  = grant;
                    valid_nxt = 1'b1;
                    read_nxt  = gnt_onehot;
                    rr_nxt    = (grant == PORT_W'(NPORTS - 1)) ? '0 : grant + PORT_W'(1);
                    state_nxt = ACK;
                end
            end
            ACK: begin
                if (out_ready) begin
                    valid_nxt = 1'b0;
                    count_nxt = item_count + CNT_W'(1);
                    state_nxt = IDLE;
                end else begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    valid_nxt = 1'b0;
                    count_nxt = item_count + CNT_W'(1);
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            rx_item_read <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_port     <= '0;
            item_count   <= '0;
        end else begin
            state        <= state_nxt;
            rr_ptr       <= rr_nxt;
            rx_item_read <= read_nxt;
            out_valid    <= valid_nxt;
            out_data     <= data_nxt;
            out_port     <= port_nxt;
            item_count   <= count_nxt;
        end
    end

endmodule

// File: tb/tb_rx_drain_arbiter.sv
// Bench for rx_drain_arbiter: receiver emulation plus a transaction-level reference model.
module tb_rx_drain_arbiter;

    localparam int NP = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [NP-1:0] rxv;
    logic [7:0]    rxd [NP];
    logic [NP*8-1:0] rx_data;
    logic [NP-1:0] rx_item_read;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic [2:0]    out_port;
    logic [3:0]    item_count;

    rx_drain_arbiter #(.NPORTS(NP), .SIZE(8), .PORT_W(3), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .rx_valid(rxv), .rx_data(rx_data),
        .rx_item_read(rx_item_read), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_port(out_port), .item_count(item_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NP; i++) rx_data[i*8 +: 8] = rxd[i];
    end

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: phase 0 = waiting, 1 = word just granted, 2 = word waiting for consumer
    int          m_phase, m_rr, m_port, m_count;
    logic [7:0]  m_data;
    logic [NP-1:0] exp_read;
    logic [NP-1:0] pend_clr;
    bit          refill;

    logic [20:0] act;
    assign act = {out_valid, out_port, out_data, rx_item_read, item_count};

    function automatic logic [20:0] expv();
        return {m_phase != 0, 3'(m_port), m_data, exp_read, 4'(m_count)};
    endfunction

    function automatic int pick(input logic [NP-1:0] v, input int rr);
        for (int k = 0; k < NP; k++) begin
            int p;
            p = (rr + k) % NP;
            if (v[p]) return p;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_rr = 0; m_port = 0; m_count = 0;
        m_data = '0; exp_read = '0; pend_clr = '0;
    endtask

    // advance model with the inputs present at the edge, clock, then emulate receivers
    task automatic cyc();
        int g;
        exp_read = '0;
        if (m_phase == 0) begin
            g = pick(rxv, m_rr);
            if (g >= 0) begin
                m_port = g; m_data = rxd[g]; m_rr = (g + 1) % NP;
                m_phase = 1; exp_read[g] = 1'b1;
            end
        end else if (out_ready) begin
            m_count = (m_count + 1) % 16;
            m_phase = 0;
        end else begin
            m_phase = 2;
        end
        @(posedge clk); #1;
        for (int i = 0; i < NP; i++) begin
            if (pend_clr[i]) begin
                rxv[i] = 1'b0;
                rxd[i] = 'x;
                if (refill) begin
                    rxv[i] = 1'b1;
                    rxd[i] = 8'($urandom);
                end
            end
        end
        pend_clr = rx_item_read & rxv;
    endtask

    task automatic apply_reset();
        reset = 1'b1; out_ready = 1'b0; rxv = '0; refill = 0;
        for (int i = 0; i < NP; i++) rxd[i] = 'x;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if (act !== 21'd0) begin
            n_fail++; $display("FAIL reset act=%h exp=%h", act, 21'd0);
        end
    endtask

    task automatic test_single_port();
        apply_reset();
        rxv = 5'b00100; rxd[2] = 8'hA5; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cyc();
            n_tests++;
            if (act !== expv()) begin
                n_fail++; $display("FAIL single_port cyc%0d act=%h exp=%h", c, act, expv());
            end
            if (c == 0) begin
                n_tests++;
                if ({out_valid, out_data, out_port, rx_item_read} !== {1'b1, 8'hA5, 3'd2, 5'b00100}) begin
                    n_fail++; $display("FAIL single_port_grant act=%h exp=%h",
                        {out_valid, out_data, out_port, rx_item_read}, {1'b1, 8'hA5, 3'd2, 5'b00100});
                end
            end
        end
        n_tests++;
        if (item_count !== 4'd1) begin
            n_fail++; $display("FAIL single_port_count act=%0d exp=1", item_count);
        end
    endtask

    task automatic test_back_to_back();
        int ng;
        apply_reset();
        refill = 1; out_ready = 1'b1; rxv = '1;
        for (int i = 0; i < NP; i++) rxd[i] = 8'($urandom);
        ng = 0;
        for (int c = 0; c < 12; c++) begin
            cyc();
            n_tests++;
            if (act !== expv()) begin
                n_fail++; $display("FAIL back_to_back cyc%0d act=%h exp=%h", c, act, expv());
            end
            if (c % 2 == 0) begin
                n_tests++;
                if (out_port !== 3'(ng % NP) || rx_item_read !== 5'(1 << (ng % NP))) begin
                    n_fail++; $display("FAIL rr_order cyc%0d port=%0d read=%b exp_port=%0d",
                        c, out_port, rx_item_read, ng % NP);
                end
                ng++;
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        rxv = 5'b00010; rxd[1] = 8'h3C; out_ready = 1'b0;
        cyc();
        n_tests++;
        if (act !== expv()) begin
            n_fail++; $display("FAIL backpressure_grant act=%h exp=%h", act, expv());
        end
        rxv[3] = 1'b1; rxd[3] = 8'hC3;
        for (int c = 0; c < 6; c++) begin
            cyc();
            n_tests++;
            if (act !== expv() || out_data !== 8'h3C || rx_item_read !== 5'b0 || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL backpressure_hold cyc%0d act=%h exp=%h", c, act, expv());
            end
        end
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            cyc();
            n_tests++;
            if (act !== expv()) begin
                n_fail++; $display("FAIL backpressure_release cyc%0d act=%h exp=%h", c, act, expv());
            end
        end
        n_tests++;
        if (out_port !== 3'd3 || out_data !== 8'hC3) begin
            n_fail++; $display("FAIL backpressure_next port=%0d data=%h exp port=3 data=c3", out_port, out_data);
        end
    endtask

    task automatic test_skip_wrap();
        apply_reset();
        out_ready = 1'b1;
        rxv = 5'b01000; rxd[3] = 8'h11;
        cyc(); cyc();
        rxv = 5'b00011; rxd[0] = 8'h22; rxd[1] = 8'h33;
        for (int c = 0; c < 4; c++) begin
            cyc();
            n_tests++;
            if (act !== expv()) begin
                n_fail++; $display("FAIL skip_wrap cyc%0d act=%h exp=%h", c, act, expv());
            end
            if (c == 0 || c == 2) begin
                n_tests++;
                if (out_port !== 3'(c / 2)) begin
                    n_fail++; $display("FAIL skip_wrap_port cyc%0d act=%0d exp=%0d", c, out_port, c / 2);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        out_ready = 1'b1;
        rxv = 5'b00011; rxd[0] = 8'h5A; rxd[1] = 8'h6B;
        cyc(); cyc(); cyc();
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (rx_item_read !== 5'b0 || out_valid !== 1'b0 || item_count !== 4'd0 || out_data !== 8'd0) begin
            n_fail++; $display("FAIL async_reset read=%b valid=%b count=%0d data=%h exp all zero",
                rx_item_read, out_valid, item_count, out_data);
        end
        model_reset();
        rxv = 5'b01000; rxd[3] = 8'h77;
        for (int i = 0; i < 3; i++) rxd[i] = 'x;
        #1 reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            cyc();
            n_tests++;
            if (act !== expv()) begin
                n_fail++; $display("FAIL async_reset_regrant cyc%0d act=%h exp=%h", c, act, expv());
            end
        end
    endtask

    task automatic test_counter_wrap();
        apply_reset();
        refill = 1; out_ready = 1'b1;
        rxv = 5'b00100; rxd[2] = 8'($urandom);
        for (int c = 0; c < 34; c++) begin
            cyc();
            n_tests++;
            if (act !== expv()) begin
                n_fail++; $display("FAIL counter_wrap cyc%0d act=%h exp=%h", c, act, expv());
            end
        end
        n_tests++;
        if (item_count !== 4'd1) begin
            n_fail++; $display("FAIL counter_wrap_final act=%0d exp=1", item_count);
        end
    endtask

    task automatic test_random();
        logic [NP-1:0] add;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            add = 5'($urandom) & 5'($urandom) & ~rxv;
            for (int i = 0; i < NP; i++) begin
                if (add[i]) begin
                    rxv[i] = 1'b1;
                    rxd[i] = 8'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cyc();
            n_tests++;
            if (act !== expv() || $countones(rx_item_read) > 1) begin
                n_fail++; $display("FAIL random cyc%0d act=%h exp=%h", c, act, expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_port();
        test_back_to_back();
        test_backpressure();
        test_skip_wrap();
        test_async_reset();
        test_counter_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
